// File: rtl/jedro_1_decoder.sv
// jedro_1_decoder: single-issue RV32I instruction decoder with a one-cycle
// registered output stage, an LSU handshake stall and a halt-on-illegal state.
// Optional CSR decoding is enabled by defining JEDRO_1_DECODER_CSR_EN.
module jedro_1_decoder (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] addr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic        out_valid_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic [31:0] imm_o,
    output logic        use_imm_o,
    output logic [3:0]  alu_sel_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic [3:0]  lsu_ctrl_o,
    output logic        illegal_instr_o,
    output logic        lsu_req_o,
    input  logic        lsu_done_i
`ifdef JEDRO_1_DECODER_CSR_EN
    ,
    output logic [11:0] csr_addr_o,
    output logic [2:0]  csr_op_o,
    output logic        csr_o
`endif
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {RUN, LSU_WAIT, HALT} state_e;

    state_e state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        accept;

    // combinational decode results
    logic        dec_rd_we, dec_use_imm, dec_branch, dec_jal, dec_jalr;
    logic        dec_lsu, dec_illegal;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_sel, dec_lsu_ctrl;
`ifdef JEDRO_1_DECODER_CSR_EN
    logic        dec_csr;
`endif

    // output register stage
    logic        out_valid_q, out_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic [31:0] imm_q, imm_d;
    logic        use_imm_q, use_imm_d;
    logic [3:0]  alu_sel_q, alu_sel_d;
    logic        branch_q, branch_d, jal_q, jal_d, jalr_q, jalr_d;
    logic [3:0]  lsu_ctrl_q, lsu_ctrl_d;
    logic        illegal_q, illegal_d;
    logic        lsu_req_q, lsu_req_d;
`ifdef JEDRO_1_DECODER_CSR_EN
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [2:0]  csr_op_q, csr_op_d;
    logic        csr_q, csr_d;
`endif

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign accept = valid_i & ready_o & ~flush_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= RUN;
        else         state_q <= state_d;
    end

    // FSM next-state: LSU accesses stall until done, illegal halts until flush
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (dec_illegal)  state_d = HALT;
                    else if (dec_lsu) state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: if (lsu_done_i) state_d = RUN;
            HALT:     if (flush_i)    state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // FSM output: accept only in RUN and never while reset is asserted
    always_comb begin
        ready_o = (state_q == RUN) & rstn_i;
    end

    // Instruction decode of the word currently on instr_i
    always_comb begin
        dec_rd_we    = 1'b0;
        dec_use_imm  = 1'b0;
        dec_branch   = 1'b0;
        dec_jal      = 1'b0;
        dec_jalr     = 1'b0;
        dec_lsu      = 1'b0;
        dec_illegal  = 1'b0;
        dec_imm      = '0;
        dec_alu_sel  = '0;
        dec_lsu_ctrl = '0;
`ifdef JEDRO_1_DECODER_CSR_EN
        dec_csr      = 1'b0;
`endif
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_imm     = imm_u;
                dec_use_imm = 1'b1;
                dec_rd_we   = 1'b1;
            end
            OPC_JAL: begin
                dec_imm   = imm_j;
                dec_jal   = 1'b1;
                dec_rd_we = 1'b1;
            end
            OPC_JALR: begin
                dec_imm     = imm_i;
                dec_use_imm = 1'b1;
                dec_jalr    = 1'b1;
                dec_rd_we   = 1'b1;
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm     = imm_b;
                dec_branch  = 1'b1;
                dec_alu_sel = {1'b0, funct3};
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm      = imm_i;
                dec_use_imm  = 1'b1;
                dec_rd_we    = 1'b1;
                dec_lsu      = 1'b1;
                dec_lsu_ctrl = {1'b0, funct3};
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_imm      = imm_s;
                dec_use_imm  = 1'b1;
                dec_lsu      = 1'b1;
                dec_lsu_ctrl = {1'b1, funct3};
                if (funct3[2] || funct3 == 3'b011) dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_imm     = imm_i;
                dec_use_imm = 1'b1;
                dec_rd_we   = 1'b1;
                dec_alu_sel = {1'b0, funct3};
                if (funct3 == 3'b001) begin
                    if (funct7 != 7'b0000000) dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec_alu_sel = {funct7[5], funct3};
                    if (funct7 != 7'b0000000 && funct7 != 7'b0100000) dec_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                dec_rd_we   = 1'b1;
                dec_alu_sel = {funct7[5], funct3};
                if (funct7 == 7'b0100000) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101) dec_illegal = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            OPC_SYSTEM: begin
`ifdef JEDRO_1_DECODER_CSR_EN
                if (funct3 == 3'b000 || funct3 == 3'b100) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_csr   = 1'b1;
                    dec_imm   = imm_i;
                    dec_rd_we = 1'b1;
                end
`else
                dec_illegal = 1'b1;
`endif
            end
            default: dec_illegal = 1'b1;
        endcase
        // illegal words must have no architectural side effects
        if (dec_illegal) begin
            dec_rd_we  = 1'b0;
            dec_lsu    = 1'b0;
            dec_branch = 1'b0;
            dec_jal    = 1'b0;
            dec_jalr   = 1'b0;
`ifdef JEDRO_1_DECODER_CSR_EN
            dec_csr    = 1'b0;
`endif
        end
        if (instr_i[11:7] == 5'd0) dec_rd_we = 1'b0;
    end

    // Output stage next values: load on accept, else hold with one-cycle pulses cleared
    always_comb begin
        out_valid_d = 1'b0;
        lsu_req_d   = 1'b0;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_sel_d   = alu_sel_q;
        branch_d    = branch_q;
        jal_d       = jal_q;
        jalr_d      = jalr_q;
        lsu_ctrl_d  = lsu_ctrl_q;
        illegal_d   = illegal_q;
`ifdef JEDRO_1_DECODER_CSR_EN
        csr_addr_d  = csr_addr_q;
        csr_op_d    = csr_op_q;
        csr_d       = csr_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            lsu_req_d   = dec_lsu;
            pc_d        = addr_i;
            rs1_d       = instr_i[19:15];
            rs2_d       = instr_i[24:20];
            rd_d        = instr_i[11:7];
            rd_we_d     = dec_rd_we;
            imm_d       = dec_imm;
            use_imm_d   = dec_use_imm;
            alu_sel_d   = dec_alu_sel;
            branch_d    = dec_branch;
            jal_d       = dec_jal;
            jalr_d      = dec_jalr;
            lsu_ctrl_d  = dec_lsu_ctrl;
            illegal_d   = dec_illegal;
`ifdef JEDRO_1_DECODER_CSR_EN
            csr_addr_d  = instr_i[31:20];
            csr_op_d    = funct3;
            csr_d       = dec_csr;
`endif
        end else if (state_q == HALT && flush_i) begin
            illegal_d = 1'b0;
        end
    end

    // Output stage registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            lsu_req_q   <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_sel_q   <= '0;
            branch_q    <= 1'b0;
            jal_q       <= 1'b0;
            jalr_q      <= 1'b0;
            lsu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
`ifdef JEDRO_1_DECODER_CSR_EN
            csr_addr_q  <= '0;
            csr_op_q    <= '0;
            csr_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            lsu_req_q   <= lsu_req_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_sel_q   <= alu_sel_d;
            branch_q    <= branch_d;
            jal_q       <= jal_d;
            jalr_q      <= jalr_d;
            lsu_ctrl_q  <= lsu_ctrl_d;
            illegal_q   <= illegal_d;
`ifdef JEDRO_1_DECODER_CSR_EN
            csr_addr_q  <= csr_addr_d;
            csr_op_q    <= csr_op_d;
            csr_q       <= csr_d;
`endif
        end
    end

    assign out_valid_o     = out_valid_q;
    assign lsu_req_o       = lsu_req_q;
    assign pc_o            = pc_q;
    assign rs1_o           = rs1_q;
    assign rs2_o           = rs2_q;
    assign rd_o            = rd_q;
    assign rd_we_o         = rd_we_q;
    assign imm_o           = imm_q;
    assign use_imm_o       = use_imm_q;
    assign alu_sel_o       = alu_sel_q;
    assign branch_o        = branch_q;
    assign jal_o           = jal_q;
    assign jalr_o          = jalr_q;
    assign lsu_ctrl_o      = lsu_ctrl_q;
    assign illegal_instr_o = illegal_q;
`ifdef JEDRO_1_DECODER_CSR_EN
    assign csr_addr_o      = csr_addr_q;
    assign csr_op_o        = csr_op_q;
    assign csr_o           = csr_q;
`endif

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Directed testbench for jedro_1_decoder; CSR checks follow JEDRO_1_DECODER_CSR_EN.
module tb_jedro_1_decoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr, addr;
    logic        valid, ready, flush;
    logic        out_valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu_sel;
    logic        branch, jal, jalr;
    logic [3:0]  lsu_ctrl;
    logic        illegal, lsu_req, lsu_done;
`ifdef JEDRO_1_DECODER_CSR_EN
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic        csr;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    jedro_1_decoder dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .instr_i         (instr),
        .addr_i          (addr),
        .valid_i         (valid),
        .ready_o         (ready),
        .flush_i         (flush),
        .out_valid_o     (out_valid),
        .pc_o            (pc),
        .rs1_o           (rs1),
        .rs2_o           (rs2),
        .rd_o            (rd),
        .rd_we_o         (rd_we),
        .imm_o           (imm),
        .use_imm_o       (use_imm),
        .alu_sel_o       (alu_sel),
        .branch_o        (branch),
        .jal_o           (jal),
        .jalr_o          (jalr),
        .lsu_ctrl_o      (lsu_ctrl),
        .illegal_instr_o (illegal),
        .lsu_req_o       (lsu_req),
        .lsu_done_i      (lsu_done)
`ifdef JEDRO_1_DECODER_CSR_EN
        ,
        .csr_addr_o      (csr_addr),
        .csr_op_o        (csr_op),
        .csr_o           (csr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction for a single edge, then drop valid
    task automatic issue(input logic [31:0] ins, input logic [31:0] a);
        instr = ins;
        addr  = a;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; valid = 1'b0; flush = 1'b0; lsu_done = 1'b0;
        instr = '0; addr = '0;
        step();
        step();
        chk("rst_ready",   32'(ready), 0);
        chk("rst_ovalid",  32'(out_valid), 0);
        chk("rst_lsu_req", 32'(lsu_req), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_rd_we",   32'(rd_we), 0);
        chk("rst_imm",     imm, 0);
        chk("rst_pc",      pc, 0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", 32'(ready), 1);

        // addi x1,x0,5
        issue(32'h00500093, 32'h0000_0100);
        chk("addi_ovalid",  32'(out_valid), 1);
        chk("addi_rd",      32'(rd), 1);
        chk("addi_rd_we",   32'(rd_we), 1);
        chk("addi_imm",     imm, 5);
        chk("addi_use_imm", 32'(use_imm), 1);
        chk("addi_alu",     32'(alu_sel), 0);
        chk("addi_pc",      pc, 32'h100);
        chk("addi_lsu_req", 32'(lsu_req), 0);
        step();
        chk("idle_ovalid",  32'(out_valid), 0);
        chk("idle_rd_hold", 32'(rd), 1);
        chk("idle_imm_hold", imm, 5);
        chk("idle_ready",   32'(ready), 1);

        // addi x1,x0,-1 : negative I immediate
        issue(32'hFFF00093, 32'h104);
        chk("addin_imm", imm, 32'hFFFF_FFFF);
        // nop (addi x0,x0,0): rd=x0 suppresses write
        issue(32'h00000013, 32'h108);
        chk("nop_ovalid", 32'(out_valid), 1);
        chk("nop_rd_we",  32'(rd_we), 0);
        // lui x5,0x12345
        issue(32'h123452B7, 32'h10C);
        chk("lui_imm",     imm, 32'h1234_5000);
        chk("lui_rd",      32'(rd), 5);
        chk("lui_rd_we",   32'(rd_we), 1);
        chk("lui_use_imm", 32'(use_imm), 1);
        // jal x1,8
        issue(32'h008000EF, 32'h200);
        chk("jal_jal",    32'(jal), 1);
        chk("jal_imm",    imm, 8);
        chk("jal_rd_we",  32'(rd_we), 1);
        chk("jal_pc",     pc, 32'h200);
        chk("jal_branch", 32'(branch), 0);
        chk("jal_alu",    32'(alu_sel), 0);
        // sub x3,x1,x2
        issue(32'h402081B3, 32'h204);
        chk("sub_alu",     32'(alu_sel), 4'h8);
        chk("sub_use_imm", 32'(use_imm), 0);
        chk("sub_rs1",     32'(rs1), 1);
        chk("sub_rs2",     32'(rs2), 2);
        chk("sub_rd",      32'(rd), 3);
        // srai x4,x1,3
        issue(32'h4030D213, 32'h208);
        chk("srai_alu", 32'(alu_sel), 4'hD);
        chk("srai_rd",  32'(rd), 4);
        // beq x0,x0,-4
        issue(32'hFE000EE3, 32'h20C);
        chk("beq_branch",  32'(branch), 1);
        chk("beq_rd_we",   32'(rd_we), 0);
        chk("beq_imm",     imm, 32'hFFFF_FFFC);
        chk("beq_illegal", 32'(illegal), 0);

        // lw x2,0(x1): done low for accept cycle + 2 wait cycles
        lsu_done = 1'b0;
        issue(32'h0000A103, 32'h210);
        chk("lw_ovalid",   32'(out_valid), 1);
        chk("lw_lsu_req",  32'(lsu_req), 1);
        chk("lw_lsu_ctrl", 32'(lsu_ctrl), 4'b0010);
        chk("lw_rd_we",    32'(rd_we), 1);
        chk("lw_rd",       32'(rd), 2);
        chk("lw_ready_c1", 32'(ready), 0);
        flush = 1'b1;  // ignored while waiting on the LSU
        step();
        flush = 1'b0;
        chk("lw_ready_c2",    32'(ready), 0);
        chk("lw_req_pulse",   32'(lsu_req), 0);
        chk("lw_ovalid_c2",   32'(out_valid), 0);
        step();
        chk("lw_ready_c3", 32'(ready), 0);
        lsu_done = 1'b1;
        step();
        lsu_done = 1'b0;
        chk("lw_ready_run", 32'(ready), 1);

        // sw x2,4(x1) with done in the same cycle as the request
        issue(32'h0020A223, 32'h214);
        chk("sw_lsu_req",  32'(lsu_req), 1);
        chk("sw_lsu_ctrl", 32'(lsu_ctrl), 4'b1010);
        chk("sw_rd_we",    32'(rd_we), 0);
        chk("sw_imm",      imm, 4);
        chk("sw_ready",    32'(ready), 0);
        lsu_done = 1'b1;
        step();
        lsu_done = 1'b0;
        chk("sw_ready_run", 32'(ready), 1);
        chk("sw_req_clr",   32'(lsu_req), 0);

        // all-zero word is illegal; HALT until flush
        issue(32'h00000000, 32'h218);
        chk("ill_ovalid",  32'(out_valid), 1);
        chk("ill_illegal", 32'(illegal), 1);
        chk("ill_rd_we",   32'(rd_we), 0);
        chk("ill_lsu_req", 32'(lsu_req), 0);
        chk("ill_ready",   32'(ready), 0);
        instr = 32'h00000013;
        valid = 1'b1;
        step();
        chk("halt_ovalid", 32'(out_valid), 0);
        chk("halt_ready",  32'(ready), 0);
        step();
        valid = 1'b0;
        chk("halt_ready2", 32'(ready), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("halt_flush_ready",   32'(ready), 1);
        chk("halt_flush_illegal", 32'(illegal), 0);

        // flush wins over valid
        instr = 32'h00000013; valid = 1'b1; flush = 1'b1;
        step();
        chk("flush_ovalid", 32'(out_valid), 0);
        chk("flush_ready",  32'(ready), 1);
        instr = 32'h0000A103;
        step();
        valid = 1'b0; flush = 1'b0;
        chk("flush_lw_ovalid",  32'(out_valid), 0);
        chk("flush_lw_lsu_req", 32'(lsu_req), 0);
        chk("flush_lw_ready",   32'(ready), 1);

        // mul is not RV32I: bad funct7
        issue(32'h020081B3, 32'h21C);
        chk("mul_illegal", 32'(illegal), 1);
        chk("mul_rd_we",   32'(rd_we), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mul_flush_ready", 32'(ready), 1);

        // csrrw x1,0x300,x2
        issue(32'h300110F3, 32'h220);
`ifdef JEDRO_1_DECODER_CSR_EN
        chk("csr_csr",     32'(csr), 1);
        chk("csr_addr",    32'(csr_addr), 12'h300);
        chk("csr_op",      32'(csr_op), 1);
        chk("csr_rd_we",   32'(rd_we), 1);
        chk("csr_illegal", 32'(illegal), 0);
        chk("csr_ready",   32'(ready), 1);
`else
        chk("csr_illegal", 32'(illegal), 1);
        chk("csr_ready",   32'(ready), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        // ecall is illegal in both builds
        issue(32'h00000073, 32'h224);
        chk("ecall_illegal", 32'(illegal), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ecall_flush_ready", 32'(ready), 1);

        // asynchronous reset in HALT
        issue(32'h00000000, 32'h228);
        #2 rstn = 1'b0;
        #1;
        chk("arst_halt_illegal", 32'(illegal), 0);
        chk("arst_halt_ovalid",  32'(out_valid), 0);
        chk("arst_halt_ready",   32'(ready), 0);
        chk("arst_halt_imm",     imm, 0);
        rstn = 1'b1;
        step();
        chk("arst_halt_ready_after", 32'(ready), 1);

        // asynchronous reset in LSU_WAIT: no request re-issue
        lsu_done = 1'b0;
        issue(32'h0000A103, 32'h22C);
        chk("arst_lsu_req_before", 32'(lsu_req), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_lsu_req", 32'(lsu_req), 0);
        rstn = 1'b1;
        step();
        chk("arst_lsu_ready",   32'(ready), 1);
        chk("arst_lsu_req_n1",  32'(lsu_req), 0);
        step();
        chk("arst_lsu_req_n2",  32'(lsu_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_decoder.md
JEDRO_1_DECODER -- requirements
Module: jedro_1_decoder

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock, all sequential logic on rising edge.
REQ-002 SHALL have ports: rstn_i  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: instr_i  in  32  instruction word from fetch unit; addr_i  in  32  its PC; valid_i  in  1  instr_i/addr_i valid.
REQ-004 SHALL have ports: ready_o  out  1  decoder accepts instr_i this cycle.
REQ-005 SHALL have ports: flush_i  in  1  squash decoded/held instruction (jump taken).
REQ-006 SHALL have registered outputs: out_valid_o 1; pc_o 32; rs1_o 5; rs2_o 5; rd_o 5; rd_we_o 1; imm_o 32; use_imm_o 1; alu_sel_o 4; branch_o 1; jal_o 1; jalr_o 1; lsu_ctrl_o 4 (bit3 store, bits2:0 funct3); illegal_instr_o 1.
REQ-007 SHALL have LSU handshake: lsu_req_o  out  1  one-cycle access request; lsu_done_i  in  1  access complete.
REQ-008 SHALL have, with JEDRO_1_DECODER_CSR_EN only: csr_addr_o out 12; csr_op_o out 3 (funct3); csr_o out 1.

Function
REQ-009 SHALL implement FSM states RUN, LSU_WAIT, HALT; ready_o = (state==RUN) & rstn_i.
REQ-010 SHALL accept an instruction when valid_i & ready_o & ~flush_i; decode outputs and out_valid_o=1 appear on the next edge (latency 1 cycle).
REQ-011 out_valid_o SHALL be 1 for exactly one cycle per accepted instruction, else 0; other outputs hold last value when out_valid_o=0.
REQ-012 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (as NOP), SYSTEM; all other opcodes, or invalid funct3/funct7, are illegal.
REQ-013 imm_o SHALL be sign-extended to 32 bits per I/S/B/U/J format; B/J immediates carry bit0=0; U-type is imm[31:12]<<12.
REQ-014 rd_we_o SHALL be 0 for BRANCH, STORE, MISC-MEM, illegal, and whenever rd=x0.
REQ-015 alu_sel_o SHALL encode {funct7[5],funct3} for OP and OP-IMM shifts, {0,funct3} for other OP-IMM, ADD (4'b0000) for LOAD/STORE/AUIPC/LUI/JAL/JALR.
REQ-016 On accepting LOAD/STORE: lsu_req_o=1 in the cycle out_valid_o=1, state -> LSU_WAIT; ready_o=0 until lsu_done_i=1; then state -> RUN on the next edge.
REQ-017 lsu_done_i in the same cycle as lsu_req_o SHALL be honoured (LSU_WAIT lasts one cycle).
REQ-018 On accepting an illegal instruction: illegal_instr_o=1 with out_valid_o=1 for one cycle, rd_we_o=0, lsu_req_o=0, state -> HALT; HALT holds ready_o=0 until flush_i.
REQ-019 flush_i in RUN SHALL discard instr_i that cycle and force out_valid_o=0 and lsu_req_o=0 on the next edge; flush_i wins over valid_i.
REQ-020 flush_i in HALT SHALL move state to RUN and clear illegal_instr_o on the next edge.
REQ-021 flush_i in LSU_WAIT SHALL be ignored; the outstanding access completes normally.
REQ-022 valid_i=0 in RUN SHALL produce out_valid_o=0 next cycle and no state change.

Reset
REQ-023 rstn_i low SHALL asynchronously force state=RUN, ready_o=0, out_valid_o=0, lsu_req_o=0, illegal_instr_o=0, rd_we_o=0, all other registered outputs 0.
REQ-024 First edge after rstn_i rises SHALL see ready_o=1; reset mid-LSU_WAIT or mid-HALT SHALL abandon it with no lsu_req_o re-issue.

Configuration
REQ-025 Macro JEDRO_1_DECODER_CSR_EN defined: SYSTEM funct3!=0 decodes as CSR (csr_o=1, csr_addr_o=instr[31:20], csr_op_o=funct3, funct3 100 illegal, rd_we_o per REQ-014); ECALL/EBREAK illegal.
REQ-026 Macro undefined: csr_* ports absent, every SYSTEM opcode illegal.

Verification
REQ-027 Reset then instr_i=0x00500093 (addi x1,x0,5), valid_i=1 -> next cycle out_valid_o=1, rd_o=1, rd_we_o=1, imm_o=5, use_imm_o=1, alu_sel_o=0.
REQ-028 instr_i=0x0000A103 (lw x2,0(x1)), lsu_done_i low 3 cycles -> lsu_req_o one pulse, ready_o=0 exactly 3 cycles, RUN on the edge after lsu_done_i=1.
REQ-029 instr_i=0x00000000 -> illegal_instr_o=1 one cycle, ready_o=0 held; flush_i=1 -> ready_o=1 next cycle.
REQ-030 valid_i=1, flush_i=1 same cycle with instr_i=0x00000013 -> out_valid_o=0 next cycle, state RUN.
REQ-031 instr_i=0x300110F3 (csrrw x1,0x300,x2): with CSR_EN -> csr_o=1, csr_addr_o=0x300, csr_op_o=1, rd_we_o=1; without -> illegal_instr_o=1.
REQ-032 instr_i=0xFE000EE3 (beq x0,x0,-4) -> branch_o=1, rd_we_o=0, imm_o=0xFFFFFFFC.
